// File: rtl/cl_tnn_frame_sched.sv
// ---------------------------------------------------------------------------
// cl_tnn_frame_sched
//
// Frame scheduler in front of a TNN accelerator. It waits until a whole image
// is buffered in the input FIFO and the output FIFO has room for a whole
// image of results. It then reads exactly IMG_BEATS beats into the
// accelerator, and it tracks result beats to retire images. It allows up to
// MAX_INFLIGHT images to be outstanding at once.
//
// Optional feature: define TNN_SCHED_TIMEOUT_EN to add a result watchdog.
// The watchdog sets err_sticky[2] when TIMEOUT_CYC cycles pass with images
// outstanding and no result beat. Without the macro, err_sticky[2] is 0.
//
// Ports
//   aclk, aresetn  clock / asynchronous active-low reset (sync release)
//   sched_en       permit new image starts (checked only in IDLE)
//   err_clr        pulse clearing err_sticky
//   in_buffered    input FIFO holds >= one image
//   in_empty       input FIFO empty (pauses reads)
//   in_vld         input FIFO read data valid (one cycle after a read)
//   out_space      output FIFO can take one image of results
//   res_vld        accelerator result beat
//   in_rd_en       input FIFO read enable
//   tnn_in_vld     accelerator input valid
//   img_start      pulse: image issued
//   img_done       pulse: last result beat of an image received
//   inflight       outstanding image count
//   img_cnt        completed images (wraps)
//   sched_busy     FSM not idle or images outstanding
//   err_sticky     {timeout, result overflow, spurious in_vld}
// ---------------------------------------------------------------------------
module cl_tnn_frame_sched #(
    parameter int IMG_BEATS    = 1024,
    parameter int OUT_BEATS    = 64,
    parameter int MAX_INFLIGHT = 2,
    parameter int TIMEOUT_CYC  = 65536
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        sched_en,
    input  logic        err_clr,
    input  logic        in_buffered,
    input  logic        in_empty,
    input  logic        in_vld,
    input  logic        out_space,
    input  logic        res_vld,
    output logic        in_rd_en,
    output logic        tnn_in_vld,
    output logic        img_start,
    output logic        img_done,
    output logic [3:0]  inflight,
    output logic [31:0] img_cnt,
    output logic        sched_busy,
    output logic [2:0]  err_sticky
);

    localparam int RW = $clog2(IMG_BEATS + 1);
    localparam int OW = $clog2(OUT_BEATS + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    // Reset pipe: assertion is immediate, and release is aligned to aclk.
    logic [1:0] rst_pipe_q;
    logic       rst_n;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_pipe_q <= 2'b00;
        else          rst_pipe_q <= {rst_pipe_q[0], 1'b1};
    end
    assign rst_n = rst_pipe_q[1];

    state_e          state_q;
    logic [RW-1:0]   rd_cnt_q;
    logic [RW-1:0]   vld_cnt_q;
    logic [OW-1:0]   res_cnt_q;
    logic [3:0]      inflight_q, inflight_d;
    logic [31:0]     img_cnt_q;
    logic [2:0]      err_q, err_d;
    logic            img_start_q, img_done_q;

    logic start_go, rd_last, vld_fire, vld_last;
    logic res_ok, res_wrap, spur, ovf, tmo;

    assign start_go = (state_q == IDLE) && sched_en && in_buffered && out_space &&
                      (inflight_q < 4'(MAX_INFLIGHT));
    assign in_rd_en = (state_q == ISSUE) && !in_empty;
    assign rd_last  = (rd_cnt_q == RW'(IMG_BEATS - 1));

    // Read data is forwarded with no added latency. Data arriving in IDLE
    // belongs to no image, so it is blocked and flagged.
    assign tnn_in_vld = in_vld && (state_q != IDLE);
    assign vld_fire   = tnn_in_vld;
    assign vld_last   = (vld_cnt_q == RW'(IMG_BEATS - 1));
    assign spur       = in_vld && (state_q == IDLE);

    // A result beat with nothing outstanding is an error. It is not counted.
    assign res_ok   = res_vld && (inflight_q != 4'd0);
    assign res_wrap = res_ok && (res_cnt_q == OW'(OUT_BEATS - 1));
    assign ovf      = res_vld && (inflight_q == 4'd0);

`ifdef TNN_SCHED_TIMEOUT_EN
    logic [31:0] wd_q;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n)                              wd_q <= '0;
        else if (inflight_q == 4'd0 || res_vld)  wd_q <= '0;
        else if (wd_q != 32'(TIMEOUT_CYC))       wd_q <= wd_q + 32'd1;
    end
    // The flag fires on the cycle that brings the count to TIMEOUT_CYC.
    // After that the counter saturates.
    assign tmo = (inflight_q != 4'd0) && !res_vld && (wd_q == 32'(TIMEOUT_CYC - 1));
`else
    logic tmo_unused;
    assign tmo_unused = (TIMEOUT_CYC == 0);
    assign tmo        = 1'b0;
`endif

    always_comb begin
        inflight_d = inflight_q;
        case ({start_go, res_wrap})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
        endcase
        // If a set event and err_clr occur in the same cycle, the set event wins.
        err_d = (err_clr ? 3'b000 : err_q) | {tmo, ovf, spur};
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_cnt_q    <= '0;
            vld_cnt_q   <= '0;
            res_cnt_q   <= '0;
            inflight_q  <= 4'd0;
            img_cnt_q   <= 32'd0;
            err_q       <= 3'b000;
            img_start_q <= 1'b0;
            img_done_q  <= 1'b0;
        end else begin
            img_start_q <= start_go;
            img_done_q  <= res_wrap;
            inflight_q  <= inflight_d;
            err_q       <= err_d;

            if (res_ok)   res_cnt_q <= res_wrap ? '0 : res_cnt_q + 1'b1;
            if (res_wrap) img_cnt_q <= img_cnt_q + 32'd1;
            if (vld_fire) vld_cnt_q <= vld_last ? '0 : vld_cnt_q + 1'b1;

            case (state_q)
                IDLE: if (start_go) state_q <= ISSUE;
                ISSUE: begin
                    if (in_rd_en) begin
                        if (rd_last) begin
                            rd_cnt_q <= '0;
                            state_q  <= DRAIN;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + 1'b1;
                        end
                    end
                end
                // Hold until the last read's data reaches the accelerator.
                DRAIN: if (vld_fire && vld_last) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign img_start  = img_start_q;
    assign img_done   = img_done_q;
    assign inflight   = inflight_q;
    assign img_cnt    = img_cnt_q;
    assign err_sticky = err_q;
    assign sched_busy = (state_q != IDLE) || (inflight_q != 4'd0);

endmodule

// File: doc/cl_tnn_frame_sched.md
CL_TNN_FRAME_SCHED -- requirements
Module: cl_tnn_frame_sched

Interface
REQ-001 SHALL have parameter IMG_BEATS, default 1024: 64-bit input beats per image.
REQ-002 SHALL have parameter OUT_BEATS, default 64: 64-bit result beats per image.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 2: images issued but not fully returned (1..15).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 65536: watchdog limit in cycles.
REQ-005 aclk  in  1  sole clock; all logic on rising edge.
REQ-006 aresetn  in  1  asynchronous, active-low reset.
REQ-007 sched_en  in  1  permit new image starts.
REQ-008 err_clr  in  1  single-cycle pulse clearing err_sticky.
REQ-009 in_buffered  in  1  input FIFO holds at least one full image.
REQ-010 in_empty  in  1  input FIFO empty.
REQ-011 in_vld  in  1  input FIFO read data valid, one cycle after a read.
REQ-012 out_space  in  1  output FIFO has room for one full image of results.
REQ-013 res_vld  in  1  accelerator result beat valid.
REQ-014 in_rd_en  out  1  input FIFO read enable.
REQ-015 tnn_in_vld  out  1  accelerator input valid.
REQ-016 img_start  out  1  one-cycle pulse when an image is issued.
REQ-017 img_done  out  1  one-cycle pulse when the last result beat of an image arrives.
REQ-018 inflight  out  4  outstanding image count.
REQ-019 img_cnt  out  32  completed images, wraps at 2^32.
REQ-020 sched_busy  out  1  state != IDLE or inflight != 0.
REQ-021 err_sticky  out  3  bit0 spurious in_vld; bit1 result overflow; bit2 timeout.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, DRAIN; state is registered.
REQ-023 IDLE->ISSUE SHALL occur when sched_en & in_buffered & out_space & inflight<MAX_INFLIGHT; the same edge pulses img_start and increments inflight.
REQ-024 ISSUE SHALL drive in_rd_en = !in_empty (combinational from state); each asserted cycle counts one read; reads SHALL pause, not fail, while in_empty=1.
REQ-025 ISSUE->DRAIN SHALL occur on the edge of the IMG_BEATS-th read; exactly IMG_BEATS reads per image.
REQ-026 DRAIN->IDLE SHALL occur on the edge where the IMG_BEATS-th in_vld is counted; the next start is evaluated in IDLE (minimum one idle cycle between images).
REQ-027 tnn_in_vld SHALL equal in_vld & (state != IDLE), zero added latency.
REQ-028 in_vld in IDLE SHALL be dropped from tnn_in_vld and SHALL set err_sticky[0].
REQ-029 Result counter SHALL count res_vld beats modulo OUT_BEATS; on wrap: img_done pulse, inflight decrement, img_cnt increment, all on the same edge.
REQ-030 Simultaneous inflight increment and decrement SHALL leave inflight unchanged.
REQ-031 res_vld with inflight==0 SHALL set err_sticky[1] and SHALL NOT change the counter, inflight or img_cnt.
REQ-032 sched_en deassertion SHALL affect only the IDLE start decision; an image in ISSUE/DRAIN SHALL complete.
REQ-033 err_sticky bits SHALL hold until err_clr; a set event coincident with err_clr SHALL win.

Reset
REQ-034 aresetn low SHALL asynchronously force state=IDLE, all counters=0, inflight=0, img_cnt=0, err_sticky=0.
REQ-035 During and after reset, until the first start, in_rd_en, tnn_in_vld, img_start, img_done and sched_busy SHALL be 0.
REQ-036 Reset mid-image SHALL abandon the image with no img_done; release SHALL be synchronous to aclk through the existing reset pipe.

Configuration
REQ-037 Macro TNN_SCHED_TIMEOUT_EN defined: watchdog counts cycles with inflight!=0 and no res_vld, reloads on res_vld or inflight==0, and sets err_sticky[2] on reaching TIMEOUT_CYC.
REQ-038 Macro TNN_SCHED_TIMEOUT_EN undefined: no watchdog logic; err_sticky[2] tied to 0.

Verification
REQ-039 in_buffered=1, out_space=1, sched_en=1, FIFO never empty -> img_start, then 1024 consecutive in_rd_en cycles, 1024 tnn_in_vld, DRAIN then IDLE, inflight=1.
REQ-040 Repeated in_empty=1 for 5 cycles at beat 500 -> in_rd_en low for those 5 cycles, still exactly 1024 reads total.
REQ-041 MAX_INFLIGHT=2 with no results -> exactly 2 img_start; third blocked; 64 res_vld -> img_done, inflight=1, img_cnt=1, third image starts.
REQ-042 64th res_vld on the same edge as an img_start -> inflight unchanged; 1 res_vld at inflight=0 -> err_sticky=3'b010; err_clr -> 0.
REQ-043 aresetn low at read 300 -> all outputs 0 immediately; after release a full new image issues normally.
REQ-044 TNN_SCHED_TIMEOUT_EN, TIMEOUT_CYC=100, image issued with no results -> err_sticky[2]=1 after 100 cycles; without macro stays 0.
